image_ram_read_arbiter: RTL and testbench



---
 rtl/image_ram_read_arbiter_if.sv | 38 +++
 rtl/image_ram_read_arbiter.sv | 151 +++++++++++++++
 tb/tb_image_ram_read_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/image_ram_read_arbiter_if.sv
// Bus bundle between the image RAM read arbiter, its three requesters and the
// image RAM read port.
//   req/req_addr/req_len : per-requester burst request, packed i*W +: W
//   gnt                  : one-hot burst-accepted pulse
//   ram_re/ram_addr      : image RAM read enable / address
//   ram_data             : image RAM read data (1-cycle latency)
//   rd_data/rd_valid     : returned word and one-hot owner tag
//   done                 : one-hot end-of-burst pulse
//   busy                 : a burst is being issued
// slave is the arbiter side; master is the requester/RAM side.
interface image_ram_read_arbiter_if #(
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LEN_W  = 10,
  parameter int unsigned NREQ   = 3
);
  logic [NREQ-1:0]        req;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*LEN_W-1:0]  req_len;
  logic [NREQ-1:0]        gnt;
  logic                   ram_re;
  logic [ADDR_W-1:0]      ram_addr;
  logic [DATA_W-1:0]      ram_data;
  logic [DATA_W-1:0]      rd_data;
  logic [NREQ-1:0]        rd_valid;
  logic [NREQ-1:0]        done;
  logic                   busy;

  modport slave (
    input  req, req_addr, req_len, ram_data,
    output gnt, ram_re, ram_addr, rd_data, rd_valid, done, busy
  );

  modport master (
    output req, req_addr, req_len, ram_data,
    input  gnt, ram_re, ram_addr, rd_data, rd_valid, done, busy
  );
endinterface

// File: rtl/image_ram_read_arbiter.sv
// Round-robin burst arbiter for the single read port of the image RAM.
// Three requesters post (start address, word count); one burst is granted at a
// time and issued one word per cycle. Returned words are tagged with a one-hot
// owner and the last one carries a done pulse.
// Ports:
//   clk   : clock, all logic on posedge
//   reset : synchronous, active-high
//   bus   : image_ram_read_arbiter_if.slave (requests, grants, RAM port, return)
module image_ram_read_arbiter #(
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned LEN_W  = 10,
  parameter int unsigned DEPTH  = 70800,
  parameter int unsigned NREQ   = 3
) (
  input logic                     clk,
  input logic                     reset,
  image_ram_read_arbiter_if.slave bus
);

  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [ADDR_W-1:0] DepthA = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LastA  = ADDR_W'(DEPTH - 1);

  typedef enum logic {StIdle, StIssue} state_e;

  state_e            state_q, state_d;
  logic [PtrW-1:0]   ptr_q, ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [NREQ-1:0]   owner_q, owner_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  // zero-length grant waiting for its done pulse
  logic [NREQ-1:0]   zero_q, zero_d;
  // owner of the word on the RAM port this cycle; zero when the port is idle
  logic [NREQ-1:0]   re_owner_q, re_owner_d;
  logic              re_last_q, re_last_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [NREQ-1:0]   rd_valid_q, rd_valid_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              busy_q, busy_d;

  logic              win_found;
  logic [PtrW-1:0]   win_idx;
  logic [PtrW-1:0]   cand;
  logic [NREQ-1:0]   win_oh;
  logic [ADDR_W-1:0] start_addr;
  logic [LEN_W-1:0]  start_len;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      cand = PtrW'((int'(ptr_q) + k) % int'(NREQ));
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    win_oh     = NREQ'(1) << win_idx;
    start_addr = bus.req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
    start_len  = bus.req_len[int'(win_idx)*LEN_W +: LEN_W];
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    gnt_d      = '0;
    zero_d     = '0;
    re_owner_d = '0;
    re_last_d  = 1'b0;
    ram_addr_d = ram_addr_q;
    busy_d     = 1'b0;
    rd_valid_d = re_owner_q;
    done_d     = zero_q | (re_last_q ? re_owner_q : '0);

    unique case (state_q)
      StIdle: begin
        // gnt_q blocks a second grant in the cycle right after a zero-length
        // grant, before the requester has had a chance to drop req.
        if (win_found && (gnt_q == '0)) begin
          gnt_d   = win_oh;
          owner_d = win_oh;
          addr_d  = (start_addr >= DepthA) ? (start_addr - DepthA) : start_addr;
          cnt_d   = start_len;
          ptr_d   = (win_idx == PtrW'(NREQ - 1)) ? '0 : (win_idx + 1'b1);
          if (start_len == '0) begin
            zero_d = win_oh;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        re_owner_d = owner_q;
        ram_addr_d = addr_q;
        busy_d     = 1'b1;
        addr_d     = (addr_q == LastA) ? '0 : (addr_q + 1'b1);
        cnt_d      = cnt_q - 1'b1;
        if (cnt_q == LEN_W'(1)) begin
          re_last_d = 1'b1;
          state_d   = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      owner_q    <= '0;
      gnt_q      <= '0;
      zero_q     <= '0;
      re_owner_q <= '0;
      re_last_q  <= 1'b0;
      ram_addr_q <= '0;
      rd_valid_q <= '0;
      done_q     <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      gnt_q      <= gnt_d;
      zero_q     <= zero_d;
      re_owner_q <= re_owner_d;
      re_last_q  <= re_last_d;
      ram_addr_q <= ram_addr_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.ram_re   = |re_owner_q;
  assign bus.ram_addr = ram_addr_q;
  assign bus.rd_data  = bus.ram_data;
  assign bus.rd_valid = rd_valid_q;
  assign bus.done     = done_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_image_ram_read_arbiter.sv
module tb_image_ram_read_arbiter;
  localparam int unsigned ADDR_W = 19;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned LEN_W  = 10;
  localparam int unsigned DEPTH  = 70800;
  localparam int unsigned NREQ   = 3;
  localparam int          NCYC   = 500;
  localparam int          MAXC   = 520;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  image_ram_read_arbiter_if #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .NREQ(NREQ)
  ) bus ();

  image_ram_read_arbiter #(
    .ADDR_W(ADDR_W), .LEN_W(LEN_W), .DEPTH(DEPTH), .NREQ(NREQ)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] word_of(input int unsigned a);
    return DATA_W'((a * 32'd40503) ^ (a >> 7));
  endfunction

  // Image RAM: registered read, one-cycle latency.
  always @(posedge clk) if (bus.ram_re) bus.ram_data <= word_of(32'(bus.ram_addr));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input int unsigned a, input int unsigned l);
    bus.req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(a);
    bus.req_len[i*LEN_W +: LEN_W]    = LEN_W'(l);
    bus.req[i]                       = 1'b1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    bus.req = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    bus.req  = '0;
    bus.req_addr = '0;
    bus.req_len  = '0;
    step();
    step();
    n_vec += 6;
    if (bus.gnt !== '0) begin n_err++; $display("FAIL reset_gnt got %b want 000", bus.gnt); end
    if (bus.ram_re !== 1'b0) begin n_err++; $display("FAIL reset_ram_re got %b want 0", bus.ram_re); end
    if (bus.ram_addr !== '0) begin n_err++; $display("FAIL reset_ram_addr got %0d want 0", bus.ram_addr); end
    if (bus.rd_valid !== '0) begin n_err++; $display("FAIL reset_rd_valid got %b want 000", bus.rd_valid); end
    if (bus.done !== '0) begin n_err++; $display("FAIL reset_done got %b want 000", bus.done); end
    if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    reset = 1'b0;
  endtask

  // One isolated burst; expectations come from the documented timing:
  // gnt at g, word k issued at g+1+k, returned at g+2+k, done with the last word.
  task automatic test_burst(input int i, input int unsigned a, input int unsigned l,
                            input string name);
    logic [NREQ-1:0] oh;
    logic            found;
    int unsigned     base;
    logic            e_re;
    logic [NREQ-1:0] e_v, e_d;
    do_reset();
    oh = NREQ'(1) << i;
    base = (a >= DEPTH) ? a - DEPTH : a;
    set_req(i, a, l);
    found = 1'b0;
    for (int t = 0; t < 8; t++) begin
      step();
      if (bus.gnt != '0) begin found = 1'b1; break; end
    end
    n_vec++;
    if (!found) begin
      n_err++;
      $display("FAIL %s_gnt_timeout got none want %b", name, oh);
      bus.req[i] = 1'b0;
      return;
    end
    if (bus.gnt !== oh) begin n_err++; $display("FAIL %s_gnt got %b want %b", name, bus.gnt, oh); end
    bus.req[i] = 1'b0;
    for (int k = 1; k <= int'(l) + 1; k++) begin
      step();
      e_re = (k <= int'(l));
      e_v  = (k >= 2) ? oh : '0;
      e_d  = (k == int'(l) + 1) ? oh : '0;
      n_vec += 5;
      if (bus.ram_re !== e_re) begin
        n_err++; $display("FAIL %s_ram_re k=%0d got %b want %b", name, k, bus.ram_re, e_re);
      end
      if (bus.busy !== e_re) begin
        n_err++; $display("FAIL %s_busy k=%0d got %b want %b", name, k, bus.busy, e_re);
      end
      if (bus.rd_valid !== e_v) begin
        n_err++; $display("FAIL %s_rd_valid k=%0d got %b want %b", name, k, bus.rd_valid, e_v);
      end
      if (bus.done !== e_d) begin
        n_err++; $display("FAIL %s_done k=%0d got %b want %b", name, k, bus.done, e_d);
      end
      if (bus.gnt !== '0) begin
        n_err++; $display("FAIL %s_extra_gnt k=%0d got %b want 000", name, k, bus.gnt);
      end
      if (e_re) begin
        n_vec++;
        if (32'(bus.ram_addr) !== (base + k - 1) % DEPTH) begin
          n_err++;
          $display("FAIL %s_ram_addr k=%0d got %0d want %0d", name, k, bus.ram_addr,
                   (base + k - 1) % DEPTH);
        end
      end
      if (e_v != '0) begin
        n_vec++;
        if (bus.rd_data !== word_of((base + k - 2) % DEPTH)) begin
          n_err++;
          $display("FAIL %s_rd_data k=%0d got %h want %h", name, k, bus.rd_data,
                   word_of((base + k - 2) % DEPTH));
        end
      end
    end
    step();
    n_vec++;
    if (bus.ram_re !== 1'b0 || bus.done !== '0 || bus.rd_valid !== '0) begin
      n_err++;
      $display("FAIL %s_tail got re=%b done=%b valid=%b want 0/000/000", name, bus.ram_re,
               bus.done, bus.rd_valid);
    end
  endtask

  task automatic test_contention();
    logic [NREQ-1:0] gval[4];
    int              gcyc[4];
    logic [NREQ-1:0] want[4];
    int              n;
    want[0] = 3'b001; want[1] = 3'b010; want[2] = 3'b100; want[3] = 3'b001;
    do_reset();
    set_req(0, 10, 2);
    set_req(1, 200, 2);
    set_req(2, 3000, 2);
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      step();
      if (bus.gnt != '0) begin gval[n] = bus.gnt; gcyc[n] = c; n++; end
    end
    bus.req = '0;
    n_vec++;
    if (n != 4) begin
      n_err++; $display("FAIL contention_count got %0d want 4", n);
      return;
    end
    for (int j = 0; j < 4; j++) begin
      n_vec++;
      if (gval[j] !== want[j]) begin
        n_err++; $display("FAIL contention_order j=%0d got %b want %b", j, gval[j], want[j]);
      end
    end
    for (int j = 1; j < 4; j++) begin
      n_vec++;
      if (gcyc[j] - gcyc[j-1] != 3) begin
        n_err++;
        $display("FAIL contention_gap j=%0d got %0d want 3", j, gcyc[j] - gcyc[j-1]);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    int   cnt;
    logic found;
    logic saw_done;
    do_reset();
    set_req(0, 500, 10);
    found = 1'b0;
    for (int t = 0; t < 8; t++) begin
      step();
      if (bus.gnt != '0) begin found = 1'b1; break; end
    end
    bus.req[0] = 1'b0;
    cnt = 0;
    for (int t = 0; t < 12 && found; t++) begin
      step();
      if (bus.ram_re) cnt++;
      if (cnt == 4) break;
    end
    n_vec++;
    if (cnt != 4) begin n_err++; $display("FAIL rmb_issue_count got %0d want 4", cnt); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_vec += 4;
    if (bus.ram_re !== 1'b0) begin n_err++; $display("FAIL rmb_ram_re got %b want 0", bus.ram_re); end
    if (bus.rd_valid !== '0) begin n_err++; $display("FAIL rmb_rd_valid got %b want 000", bus.rd_valid); end
    if (bus.done !== '0) begin n_err++; $display("FAIL rmb_done got %b want 000", bus.done); end
    if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rmb_busy got %b want 0", bus.busy); end
    saw_done = 1'b0;
    for (int t = 0; t < 12; t++) begin
      step();
      if (bus.done != '0 || bus.ram_re) saw_done = 1'b1;
    end
    n_vec++;
    if (saw_done) begin n_err++; $display("FAIL rmb_quiet got activity want none"); end
    set_req(1, 900, 1);
    set_req(0, 40, 2);
    found = 1'b0;
    for (int t = 0; t < 8; t++) begin
      step();
      if (bus.gnt != '0) begin found = 1'b1; break; end
    end
    n_vec++;
    if (bus.gnt !== 3'b001) begin n_err++; $display("FAIL rmb_first_gnt got %b want 001", bus.gnt); end
    bus.req[0] = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 8; t++) begin
      step();
      if (bus.gnt != '0) begin found = 1'b1; break; end
    end
    n_vec++;
    if (bus.gnt !== 3'b010) begin n_err++; $display("FAIL rmb_second_gnt got %b want 010", bus.gnt); end
    bus.req = '0;
    step();
    step();
  endtask

  // Random requesters against a grant scheduler: each accepted burst books its
  // gnt/issue/return/done cycles into per-cycle expectation tables.
  task automatic test_random();
    logic [NREQ-1:0] e_gnt[MAXC];
    logic [NREQ-1:0] e_val[MAXC];
    logic [NREQ-1:0] e_done[MAXC];
    logic            e_re[MAXC];
    int unsigned     e_addr[MAXC];
    int unsigned     r_addr[NREQ];
    int unsigned     r_len[NREQ];
    int              tmr[NREQ];
    int              ptr_m, next_dec, w, g;
    logic [NREQ-1:0] oh;
    for (int c = 0; c < MAXC; c++) begin
      e_gnt[c] = '0; e_val[c] = '0; e_done[c] = '0; e_re[c] = 1'b0; e_addr[c] = 0;
    end
    for (int i = 0; i < int'(NREQ); i++) begin
      tmr[i] = int'($urandom_range(0, 3)); r_addr[i] = 0; r_len[i] = 1;
    end
    ptr_m = 0;
    next_dec = 0;
    do_reset();
    for (int c = 0; c < NCYC; c++) begin
      if (c > 0) step();
      n_vec += 5;
      if (bus.gnt !== e_gnt[c]) begin
        n_err++; $display("FAIL rnd_gnt c=%0d got %b want %b", c, bus.gnt, e_gnt[c]);
      end
      if (bus.ram_re !== e_re[c]) begin
        n_err++; $display("FAIL rnd_ram_re c=%0d got %b want %b", c, bus.ram_re, e_re[c]);
      end
      if (bus.busy !== e_re[c]) begin
        n_err++; $display("FAIL rnd_busy c=%0d got %b want %b", c, bus.busy, e_re[c]);
      end
      if (bus.rd_valid !== e_val[c]) begin
        n_err++; $display("FAIL rnd_rd_valid c=%0d got %b want %b", c, bus.rd_valid, e_val[c]);
      end
      if (bus.done !== e_done[c]) begin
        n_err++; $display("FAIL rnd_done c=%0d got %b want %b", c, bus.done, e_done[c]);
      end
      if (e_re[c]) begin
        n_vec++;
        if (32'(bus.ram_addr) !== e_addr[c]) begin
          n_err++; $display("FAIL rnd_ram_addr c=%0d got %0d want %0d", c, bus.ram_addr, e_addr[c]);
        end
      end
      if (e_val[c] != '0) begin
        n_vec++;
        if (bus.rd_data !== word_of(e_addr[c-1])) begin
          n_err++;
          $display("FAIL rnd_rd_data c=%0d got %h want %h", c, bus.rd_data, word_of(e_addr[c-1]));
        end
      end
      // Requesters: drop on grant, re-request after a random pause.
      for (int i = 0; i < int'(NREQ); i++) begin
        if (bus.gnt[i]) begin
          bus.req[i] = 1'b0;
          tmr[i] = int'($urandom_range(0, 5));
        end else if (!bus.req[i]) begin
          if (tmr[i] == 0) begin
            r_addr[i] = ($urandom_range(0, 3) == 0) ? DEPTH - 1 - $urandom_range(0, 3)
                                                    : $urandom_range(0, DEPTH - 1);
            r_len[i]  = $urandom_range(1, 6);
            set_req(i, r_addr[i], r_len[i]);
          end else begin
            tmr[i]--;
          end
        end
      end
      if (c >= next_dec && bus.req != '0) begin
        w = -1;
        for (int k = 0; k < int'(NREQ); k++) begin
          if (w < 0 && bus.req[(ptr_m + k) % int'(NREQ)]) w = (ptr_m + k) % int'(NREQ);
        end
        g  = c + 1;
        oh = NREQ'(1) << w;
        e_gnt[g] = oh;
        for (int j = 0; j < int'(r_len[w]); j++) begin
          e_re[g+1+j]   = 1'b1;
          e_addr[g+1+j] = (r_addr[w] + j) % DEPTH;
          e_val[g+2+j]  = oh;
        end
        e_done[g+1+int'(r_len[w])] = oh;
        ptr_m    = (w + 1) % int'(NREQ);
        next_dec = g + int'(r_len[w]);
      end
    end
    bus.req = '0;
  endtask

  initial begin
    bus.req      = '0;
    bus.req_addr = '0;
    bus.req_len  = '0;
    test_reset();
    test_burst(0, 100, 4, "single");
    test_burst(1, 70798, 4, "wrap");
    test_burst(2, 1234, 0, "zero_len");
    test_burst(0, 70805, 2, "oor_addr");
    test_contention();
    test_reset_mid_burst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
